mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execution stage.
- Accepts one executed instruction per handshake:
  - ALU result
  - store data
  - zero flag
  - branch target
  - control bits
- Performs the load/store against the data memory over a req/ack interface, stalling upstream while the access is outstanding.
- Resolves the branch (PCSrc plus target) and presents register-writeback data to the writeback stage.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/branch_unit.sv | 13 +
 rtl/mem_access_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline stages: default widths, the
// memory-stage state encoding and instruction field positions.
package cpu_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_REG_AW = 5;

    // destination register field of the instruction word
    localparam int RD_LSB = 0;
    localparam int RD_MSB = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/branch_unit.sv
// Combinational branch decision from the unconditional / CBZ / CBNZ flags
// and the ALU zero flag. Also used by the fetch-stage verification model.
module branch_unit (
    input  logic b,
    input  logic bz,
    input  logic bnz,
    input  logic zero,
    output logic taken
);

    assign taken = b | (bz & zero) | (bnz & ~zero);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: performs loads/stores over a req/ack port,
// resolves branches and presents writeback data. Optional build macro:
// MEM_ALIGN_CHECK_EN rejects memory accesses that are not 8-byte aligned.
//
// state | meaning
// IDLE  | ready for a new instruction; non-memory ops complete in one cycle
// WAIT  | memory request outstanding, upstream stalled until ack or timeout
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_AW      = DEF_REG_AW,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_instr,
    input  logic [DATA_W-1:0] ex_branch_addr,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_zero,
    input  logic              ex_b,
    input  logic              ex_bz,
    input  logic              ex_bnz,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;

    logic              taken;
    logic              accept;
    logic              is_mem;
    logic              misaligned;
    logic              bad_access;
    logic              start_access;
    logic              ack_hit;
    logic              timeout_hit;

    // instruction fields kept while the memory access is outstanding
    logic [REG_AW-1:0] p_rd;
    logic              p_reg_write;
    logic              p_mem_to_reg;
    logic              p_taken;
    logic [DATA_W-1:0] p_target;

    logic              unused_instr_bits;
    assign unused_instr_bits = ^ex_instr[31:RD_MSB+1];

    branch_unit u_branch (
        .b     (ex_b),
        .bz    (ex_bz),
        .bnz   (ex_bnz),
        .zero  (ex_zero),
        .taken (taken)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |ex_alu_result[2:0];
`else
    assign misaligned = 1'b0;
`endif

    assign accept       = ex_valid & ex_ready;
    assign is_mem       = ex_mem_read | ex_mem_write;
    assign bad_access   = is_mem & ((ex_mem_read & ex_mem_write) | misaligned);
    assign start_access = accept & is_mem & ~bad_access;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_access) next_state = WAIT;
            WAIT: if (ack_hit || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ex_ready    = (state == IDLE);
        ack_hit     = (state == WAIT) & dmem_req & dmem_ack;
        timeout_hit = (state == WAIT) & dmem_req & ~dmem_ack & (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            pc_src        <= 1'b0;
            branch_target <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            mem_err       <= 1'b0;
            p_rd          <= '0;
            p_reg_write   <= 1'b0;
            p_mem_to_reg  <= 1'b0;
            p_taken       <= 1'b0;
            p_target      <= '0;
        end else begin
            wb_valid <= 1'b0;
            pc_src   <= 1'b0;
            mem_err  <= 1'b0;
            if (accept) begin
                if (start_access) begin
                    cnt          <= '0;
                    dmem_req     <= 1'b1;
                    dmem_we      <= ex_mem_write;
                    dmem_addr    <= ex_alu_result;
                    dmem_wdata   <= ex_store_data;
                    p_rd         <= REG_AW'(ex_instr[RD_MSB:RD_LSB]);
                    p_reg_write  <= ex_reg_write;
                    p_mem_to_reg <= ex_mem_to_reg;
                    p_taken      <= taken;
                    p_target     <= ex_branch_addr;
                end else begin
                    wb_valid      <= 1'b1;
                    wb_rd         <= REG_AW'(ex_instr[RD_MSB:RD_LSB]);
                    wb_data       <= ex_alu_result;
                    branch_target <= ex_branch_addr;
                    if (bad_access) begin
                        mem_err      <= 1'b1;
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_reg_write <= ex_reg_write;
                        pc_src       <= taken;
                    end
                end
            end else if (state == WAIT) begin
                if (ack_hit) begin
                    cnt           <= '0;
                    dmem_req      <= 1'b0;
                    wb_valid      <= 1'b1;
                    wb_reg_write  <= p_reg_write;
                    wb_rd         <= p_rd;
                    wb_data       <= p_mem_to_reg ? dmem_rdata : dmem_addr;
                    pc_src        <= p_taken;
                    branch_target <= p_target;
                end else if (timeout_hit) begin
                    cnt          <= '0;
                    dmem_req     <= 1'b0;
                    wb_valid     <= 1'b1;
                    mem_err      <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_rd        <= p_rd;
                    wb_data      <= dmem_addr;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (ACK_TIMEOUT = 4).
// Honours MEM_ALIGN_CHECK_EN for the misaligned-address vector.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [63:0] ex_branch_addr;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_store_data;
    logic        ex_zero, ex_b, ex_bz, ex_bnz;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_W(64), .REG_AW(5), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
        .ex_branch_addr(ex_branch_addr), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_zero(ex_zero),
        .ex_b(ex_b), .ex_bz(ex_bz), .ex_bnz(ex_bnz),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc_src(pc_src), .branch_target(branch_target),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance to 1 ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] alu, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        ex_valid      = 1'b1;
        ex_instr      = 32'h8B00_0000 | {27'd0, rd};
        ex_alu_result = alu;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_mem_to_reg = m2r;
        ex_b = 1'b0; ex_bz = 1'b0; ex_bnz = 1'b0; ex_zero = 1'b0;
    endtask

    task automatic set_br(input logic b, input logic bz, input logic bnz,
                          input logic zero, input logic [63:0] tgt);
        ex_b = b; ex_bz = bz; ex_bnz = bnz; ex_zero = zero;
        ex_branch_addr = tgt;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_branch_addr = '0;
        ex_alu_result = '0; ex_store_data = '0; ex_zero = 1'b0; ex_b = 1'b0;
        ex_bz = 1'b0; ex_bnz = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
        cyc();
        check("rst_ex_ready", ex_ready, 1);
        check("rst_req",      dmem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_pc_src",   pc_src, 0);
        check("rst_mem_err",  mem_err, 0);
        check("rst_wb_data",  wb_data, 0);
        rst_n = 1'b1;
        cyc();

        // non-memory ADD then three back-to-back
        set_op(64'h10, 5'd3, 1, 0, 0, 0);
        cyc();
        check("add_wb_valid", wb_valid, 1);
        check("add_wb_rd",    wb_rd, 3);
        check("add_wb_data",  wb_data, 64'h10);
        check("add_wb_rw",    wb_reg_write, 1);
        check("add_pc_src",   pc_src, 0);
        for (int i = 0; i < 3; i++) begin
            set_op(64'h20 + 64'(i) * 64'h10, 5'(4 + i), 1, 0, 0, 0);
            cyc();
            check("b2b_wb_valid", wb_valid, 1);
            check("b2b_wb_data",  wb_data, 64'h20 + 64'(i) * 64'h10);
            check("b2b_wb_rd",    wb_rd, 64'(4 + i));
            check("b2b_ready",    ex_ready, 1);
        end
        ex_valid = 1'b0;
        cyc();
        check("idle_wb_valid", wb_valid, 0);

        // load, ack in third WAIT cycle
        set_op(64'h100, 5'd7, 1, 1, 0, 1);
        cyc();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ld_req",   dmem_req, 1);
            check("ld_ready", ex_ready, 0);
            check("ld_we",    dmem_we, 0);
            check("ld_addr",  dmem_addr, 64'h100);
            check("ld_wbv",   wb_valid, 0);
            if (i == 2) begin
                dmem_ack = 1'b1;
                dmem_rdata = 64'hDEAD_BEEF;
            end
            cyc();
        end
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("ld_req_drop", dmem_req, 0);
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_data",  wb_data, 64'hDEAD_BEEF);
        check("ld_wb_rd",    wb_rd, 7);
        check("ld_wb_rw",    wb_reg_write, 1);
        check("ld_ready2",   ex_ready, 1);
        cyc();
        check("ld_wbv_pulse", wb_valid, 0);

        // store with ack in first WAIT cycle
        set_op(64'h200, 5'd9, 0, 0, 1, 0);
        ex_store_data = 64'h55;
        cyc();
        ex_valid = 1'b0;
        check("st_req",   dmem_req, 1);
        check("st_we",    dmem_we, 1);
        check("st_wdata", dmem_wdata, 64'h55);
        check("st_addr",  dmem_addr, 64'h200);
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_rw",    wb_reg_write, 0);
        check("st_req_drop", dmem_req, 0);

        // branches
        set_op(64'h0, 5'd1, 0, 0, 0, 0);
        set_br(0, 1, 0, 1, 64'h40);
        cyc();
        check("cbz_pc_src", pc_src, 1);
        check("cbz_target", branch_target, 64'h40);
        check("cbz_wbv",    wb_valid, 1);
        set_op(64'h0, 5'd1, 0, 0, 0, 0);
        set_br(0, 0, 1, 1, 64'h80);
        cyc();
        check("cbnz_z1_pc_src", pc_src, 0);
        check("cbnz_z1_wbv",    wb_valid, 1);
        set_op(64'h0, 5'd1, 0, 0, 0, 0);
        set_br(0, 0, 1, 0, 64'h88);
        cyc();
        check("cbnz_z0_pc_src", pc_src, 1);
        check("cbnz_z0_target", branch_target, 64'h88);
        set_op(64'h0, 5'd1, 0, 0, 0, 0);
        set_br(0, 1, 0, 0, 64'h90);
        cyc();
        check("cbz_z0_pc_src", pc_src, 0);
        set_op(64'h0, 5'd1, 0, 0, 0, 0);
        set_br(1, 0, 0, 0, 64'hC0);
        cyc();
        check("b_z0_pc_src", pc_src, 1);
        check("b_z0_target", branch_target, 64'hC0);
        set_op(64'h0, 5'd1, 0, 0, 0, 0);
        set_br(1, 0, 0, 1, 64'hD0);
        cyc();
        check("b_z1_pc_src", pc_src, 1);
        check("b_z1_target", branch_target, 64'hD0);
        ex_valid = 1'b0;
        cyc();
        check("br_pulse", pc_src, 0);

        // timeout on a load that is also an unconditional branch
        set_op(64'h300, 5'd11, 1, 1, 0, 1);
        set_br(1, 0, 0, 0, 64'hE0);
        cyc();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_req",    dmem_req, 1);
            check("to_ready",  ex_ready, 0);
            check("to_err",    mem_err, 0);
            cyc();
        end
        check("to_req_drop", dmem_req, 0);
        check("to_mem_err",  mem_err, 1);
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_rw",    wb_reg_write, 0);
        check("to_pc_src",   pc_src, 0);
        check("to_ready2",   ex_ready, 1);
        dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("late_ack_wbv", wb_valid, 0);
        check("late_ack_err", mem_err, 0);
        check("late_ack_req", dmem_req, 0);

        // illegal control: read and write together
        set_op(64'h308, 5'd12, 1, 1, 1, 0);
        cyc();
        ex_valid = 1'b0;
        check("ill_req",     dmem_req, 0);
        check("ill_mem_err", mem_err, 1);
        check("ill_wbv",     wb_valid, 1);
        check("ill_wb_rw",   wb_reg_write, 0);
        check("ill_ready",   ex_ready, 1);
        cyc();
        check("ill_err_pulse", mem_err, 0);

        // reset while a load is outstanding
        set_op(64'h400, 5'd13, 1, 1, 0, 1);
        cyc();
        ex_valid = 1'b0;
        check("rw_req_before", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_req_async",   dmem_req, 0);
        check("rw_ready_async", ex_ready, 1);
        cyc();
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 64'h777;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("rw_late_ack_wbv", wb_valid, 0);
        check("rw_late_ack_req", dmem_req, 0);
        set_op(64'h108, 5'd14, 1, 1, 0, 1);
        cyc();
        ex_valid = 1'b0;
        check("rw_new_req",  dmem_req, 1);
        check("rw_new_addr", dmem_addr, 64'h108);
        dmem_ack = 1'b1; dmem_rdata = 64'h1234;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("rw_new_wbv",  wb_valid, 1);
        check("rw_new_data", wb_data, 64'h1234);
        check("rw_new_rd",   wb_rd, 14);

        // misaligned address
        set_op(64'h104, 5'd15, 1, 1, 0, 1);
        cyc();
        ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        check("al_req",     dmem_req, 0);
        check("al_mem_err", mem_err, 1);
        check("al_wbv",     wb_valid, 1);
        check("al_wb_rw",   wb_reg_write, 0);
        check("al_ready",   ex_ready, 1);
`else
        check("al_req",  dmem_req, 1);
        check("al_addr", dmem_addr, 64'h104);
        check("al_err",  mem_err, 0);
        dmem_ack = 1'b1; dmem_rdata = 64'hA5A5;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("al_wbv",  wb_valid, 1);
        check("al_data", wb_data, 64'hA5A5);
`endif
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
